huffman_stream_ctrl: RTL

//  Frame sequencer for the bit-serial Huffman decoder. Accepts packed bytes over valid/ready and

---
 rtl/huffman_pkg.sv | 20 ++
 rtl/huffman_bit_serializer.sv | 53 +++++
 rtl/huffman_stream_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared widths, FSM state type and code-table constants for the Huffman stream path.
package huffman_pkg;

  localparam int unsigned LEN_W = 16;
  localparam int unsigned SYM_W = 6;

  // Code table shared with the decoder core: 00=1 01=2 10=3 110=4 111000=5 111001=6.
  localparam int unsigned NUM_SYMS     = 6;
  localparam int unsigned MIN_CODE_LEN = 2;
  localparam int unsigned MAX_CODE_LEN = 6;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StShift,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/huffman_bit_serializer.sv
// One-byte buffer that hands packed bits to the decoder MSB-first, one per shift strobe.
module huffman_bit_serializer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       shift_i,
  output logic       full_o,
  output logic       ready_o,
  output logic       bit_o
);

  logic [7:0] byte_q, byte_d;
  logic [2:0] idx_q, idx_d;
  logic       full_q, full_d;

  always_comb begin
    byte_d = byte_q;
    idx_d  = idx_q;
    full_d = full_q;
    // Leaving the shift phase drops any unused trailing bits of the last byte.
    if (!en_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      byte_d = data_i;
      idx_d  = 3'd7;
      full_d = 1'b1;
    end else if (shift_i) begin
      idx_d = idx_q - 3'd1;
      if (idx_q == 3'd0) begin
        full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      byte_q <= 8'h00;
      idx_q  <= 3'd0;
      full_q <= 1'b0;
    end else begin
      byte_q <= byte_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

  assign full_o  = full_q;
  assign ready_o = en_i & ~full_q;
  assign bit_o   = shift_i & byte_q[idx_q];

endmodule

// File: rtl/huffman_stream_ctrl.sv
// Frame sequencer feeding the bit-serial Huffman decoder and buffering its symbols in a
// one-entry output slot with backpressure.
module huffman_stream_ctrl
  import huffman_pkg::*;
#(
  parameter int unsigned LenW = LEN_W,
  parameter int unsigned SymW = SYM_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [LenW-1:0] frame_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  output logic            dec_clr,
  output logic            dec_bit,
  output logic            dec_bit_en,
  input  logic            dec_sym_vld,
  input  logic [SymW-1:0] dec_sym,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SymW-1:0] out_sym,
  output logic            busy,
  output logic            done,
  output logic            err_trunc,
  output logic [LenW-1:0] sym_count
);

  state_e          state_q;
  logic [LenW-1:0] bits_left_q;
  logic [LenW-1:0] sym_count_q;
  logic [SymW-1:0] out_sym_q;
  logic            out_valid_q;
  logic            issued_q;
  logic            err_q;
  logic            dec_clr_q;
  logic            done_q;
  logic            busy_q;

  logic            shifting;
  logic            buf_full;
  logic            accept;
  logic            issue;
  logic            capture;

  assign shifting = (state_q == StShift);
  assign capture  = issued_q & dec_sym_vld;
  // Never issue while a symbol is landing, so the next capture always finds a free slot.
  assign issue    = shifting & buf_full & (~out_valid_q | out_ready) & ~capture;
  assign accept   = in_valid & in_ready;

  huffman_bit_serializer u_serializer (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (shifting),
    .load_i  (accept),
    .data_i  (in_data),
    .shift_i (issue),
    .full_o  (buf_full),
    .ready_o (in_ready),
    .bit_o   (dec_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bits_left_q <= '0;
      sym_count_q <= '0;
      out_sym_q   <= '0;
      out_valid_q <= 1'b0;
      issued_q    <= 1'b0;
      err_q       <= 1'b0;
      dec_clr_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      dec_clr_q <= 1'b0;
      done_q    <= 1'b0;
      issued_q  <= issue;

      if (capture) begin
        out_sym_q   <= dec_sym;
        out_valid_q <= 1'b1;
        sym_count_q <= sym_count_q + LenW'(1);
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (issue) begin
        bits_left_q <= bits_left_q - LenW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            bits_left_q <= frame_len;
            sym_count_q <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            if (frame_len == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StClr;
              dec_clr_q <= 1'b1;
            end
          end
        end
        StClr: state_q <= StShift;
        StShift: begin
          if (issue && bits_left_q == LenW'(1)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // The last bit's response arrives now; silence means the frame cut a codeword.
          if (!dec_sym_vld) begin
            err_q <= 1'b1;
          end
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dec_bit_en = issue;
  assign dec_clr    = dec_clr_q;
  assign out_valid  = out_valid_q;
  assign out_sym    = out_sym_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_trunc  = err_q;
  assign sym_count  = sym_count_q;

endmodule
